// File: rtl/sbox_hpc2_pkg.sv
// Shared constants and types for the masked Skinny S-box run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sbox_hpc2_pkg;

    localparam int ORDER   = 4;
    localparam int SHARES  = ORDER + 1;
    localparam int FRESH_W = 210;
    localparam int LAT     = 9;

    typedef logic [4*SHARES-1:0] share_nib_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

endpackage

// File: rtl/sbox_hpc2_run_ctrl_masked_share_reg.sv
// Enable-gated register bank holding N_SH independent shares of W bits each.
// Latency: 1 cycle from en to q.
// Backpressure: none; q holds its value whenever en is low.
module masked_share_reg
    import sbox_hpc2_pkg::*;
#(
    parameter int N_SH = SHARES,
    parameter int W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_SH*W-1:0] d,
    output logic [N_SH*W-1:0] q
);

    // One flop group per share; shares never share logic with each other.
    for (genvar s = 0; s < N_SH; s++) begin : g_share
        logic [W-1:0] sh_q;

        // Capture this share only when enabled, clear on reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sh_q <= '0;
            end else if (en) begin
                sh_q <= d[s*W +: W];
            end
        end

        assign q[s*W +: W] = sh_q;
    end

endmodule

// File: rtl/sbox_hpc2_run_ctrl.sv
// Drives one masked S-box evaluation per accepted (shares, fresh) pair and returns its output shares.
// Latency: accept cycle to out_valid_o is LAT+2 cycles; one evaluation per LAT+3 cycles at best.
// Backpressure: inputs stall while busy; output shares held until out_ready_i. Optional SBOX_RUN_WDOG_EN adds err_o watchdog.
module sbox_hpc2_run_ctrl
    import sbox_hpc2_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [4*SHARES-1:0]   x_sh_i,
    input  logic [FRESH_W-1:0]    fresh_i,
    input  logic                  fresh_vld_i,
    output logic                  fresh_rdy_o,
    output logic [4*SHARES-1:0]   sb_x_o,
    output logic [FRESH_W-1:0]    sb_fresh_o,
    output logic                  sb_rst_o,
    input  logic                  sb_synch_i,
    input  logic [4*SHARES-1:0]   sb_y_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4*SHARES-1:0]   y_sh_o,
    output logic                  busy_o
`ifdef SBOX_RUN_WDOG_EN
    ,
    output logic                  err_o
`endif
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       sb_rst_q;
    logic       accept;
    logic       synch_hit;
    logic       timeout;

    // Both sides must be present together; a lone valid consumes nothing.
    assign accept    = (state_q == ST_IDLE) & in_valid_i & fresh_vld_i;
    assign synch_hit = (state_q == ST_RUN) & sb_synch_i;

`ifdef SBOX_RUN_WDOG_EN
    localparam int                 CNT_W     = $clog2(LAT + 4) + 1;
    localparam logic [CNT_W-1:0]   WDOG_LAST = CNT_W'(LAT + 3);

    logic [CNT_W-1:0] wdog_q;
    logic             err_q;

    // Count RUN cycles; the value is the zero-based index of the current RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (state_q != ST_RUN) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    // Give up after LAT+4 RUN cycles with no Synch.
    assign timeout = (state_q == ST_RUN) & ~sb_synch_i & (wdog_q == WDOG_LAST);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
`endif

    // Next-state selection for the run sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (synch_hit) begin
                    state_d = ST_DONE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE:  if (out_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register and registered S-box reset: released only while in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sb_rst_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sb_rst_q <= (state_d != ST_RUN);
        end
    end

    // Input shares and fresh word are captured on accept and held until the next accept.
    masked_share_reg #(.N_SH(SHARES), .W(4)) u_x_reg (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .d   (x_sh_i),
        .q   (sb_x_o)
    );

    masked_share_reg #(.N_SH(1), .W(FRESH_W)) u_fresh_reg (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .d   (fresh_i),
        .q   (sb_fresh_o)
    );

    // Output shares are taken in the cycle the S-box signals Synch.
    masked_share_reg #(.N_SH(SHARES), .W(4)) u_y_reg (
        .clk (clk),
        .rst (rst),
        .en  (synch_hit),
        .d   (sb_y_i),
        .q   (y_sh_o)
    );

    assign in_ready_o  = (state_q == ST_IDLE) & fresh_vld_i;
    assign fresh_rdy_o = (state_q == ST_IDLE) & in_valid_i;
    assign sb_rst_o    = sb_rst_q;
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);

endmodule
